cond_logic_unit: RTL

- Stage directly downstream of the 4-bit ALU. Consumes the ALU result and its NZCV flags.
- Holds the architectural NZCV status register and evaluates the ARMv4 4-bit condition field against it.
- Gates register-write, memory-write and PC-select strobes, and presents the result through one registered writeback stage with valid.

---
 rtl/cond_pkg.sv | 35 +++
 rtl/cond_check.sv | 43 ++++
 rtl/cond_logic_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the condition-logic stage: ARM condition encodings,
// NZCV bit positions and flag-write control bit positions.
package cond_pkg;

  // ARMv4 condition field, instr[31:28]
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Bit positions inside the {N,Z,C,V} status word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Bit positions inside flagW
  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARM condition evaluator: (cond, NZCV) -> pass.
// Kept standalone so a later branch-prediction stage can reuse it.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condEx
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition field against the current status flags
  always_comb begin
    // NOTE: assigning a default before the case keeps this block free of
    // inferred latches even if an arm is later removed.
    condEx = 1'b0;
    case (cond_e'(cond))
      COND_EQ: condEx = z;
      COND_NE: condEx = ~z;
      COND_CS: condEx = c;
      COND_CC: condEx = ~c;
      COND_MI: condEx = n;
      COND_PL: condEx = ~n;
      COND_VS: condEx = v;
      COND_VC: condEx = ~v;
      COND_HI: condEx = c & ~z;
      COND_LS: condEx = ~c | z;
      COND_GE: condEx = (n == v);
      COND_LT: condEx = (n != v);
      COND_GT: condEx = ~z & (n == v);
      COND_LE: condEx = z | (n != v);
      COND_AL: condEx = 1'b1;
      COND_NV: condEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic_unit.sv
// Condition-logic stage after the ALU: holds the NZCV status register,
// gates the register/memory/PC write strobes by the condition field and
// registers the result through one writeback stage with valid.
// Optional: define COND_SKIP_CNT_EN to add a saturating skipCount output
// counting accepted instructions whose condition failed.
module cond_logic_unit
  import cond_pkg::*;
#(
  parameter int N = 4
`ifdef COND_SKIP_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             validIn,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       cond,
  input  logic [1:0]       flagW,
  input  logic             regWIn,
  input  logic             memWIn,
  input  logic             pcSIn,
  input  logic [N-1:0]     aluResult,
  input  logic [3:0]       aluFlags,
  output logic             condEx,
  output logic [3:0]       flags,
  output logic             regWrite,
  output logic             memWrite,
  output logic             pcSrc,
  output logic [N-1:0]     resultOut,
  output logic             validOut
`ifdef COND_SKIP_CNT_EN
  ,
  output logic [CNT_W-1:0] skipCount
`endif
);

  logic accepted;
  logic passing;

  // condEx looks only at the registered flags: no bypass of aluFlags
  cond_check u_cond_check (
    .cond   (cond),
    .flags  (flags),
    .condEx (condEx)
  );

  // stall beats flush: a stalled instruction is neither taken nor squashed
  assign accepted = validIn & ~stall & ~flush;
  assign passing  = accepted & condEx;

  // Architectural NZCV register, updated per half by a passing instruction
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      flags <= 4'b0000;
    end else begin
      if (passing && flagW[FW_NZ]) begin
        flags[FLAG_N] <= aluFlags[FLAG_N];
        flags[FLAG_Z] <= aluFlags[FLAG_Z];
      end
      if (passing && flagW[FW_CV]) begin
        flags[FLAG_C] <= aluFlags[FLAG_C];
        flags[FLAG_V] <= aluFlags[FLAG_V];
      end
    end
  end

  // Writeback stage: valid, gated strobes and result; holds under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validOut  <= 1'b0;
      regWrite  <= 1'b0;
      memWrite  <= 1'b0;
      pcSrc     <= 1'b0;
      resultOut <= '0;
    end else if (!stall) begin
      validOut <= accepted;
      regWrite <= passing & regWIn;
      memWrite <= passing & memWIn;
      pcSrc    <= passing & pcSIn;
      if (accepted) begin
        resultOut <= aluResult;
      end
    end
  end

`ifdef COND_SKIP_CNT_EN
  // Saturating count of accepted instructions whose condition failed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skipCount <= '0;
    end else if (accepted && !condEx && (skipCount != '1)) begin
      skipCount <= skipCount + CNT_W'(1);
    end
  end
`endif

endmodule
